// File: rtl/timer_pkg.sv
// Shared types and constants for the M:SS timer keypad front end.
package timer_pkg;
  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  localparam digit_t BCD_MAX          = 4'd9;
  localparam digit_t SEC_TENS_MAX_DEF = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_e;

  function automatic digit_t clamp_digit(input digit_t d, input digit_t max_v);
    return (d > max_v) ? max_v : d;
  endfunction
endpackage

// File: rtl/key_edge_detect.sv
// Synchronizes an asynchronous level and emits a one-cycle pulse on its rising edge.
module key_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);
  // [SYNC_STAGES-1] is the synchronized level, [SYNC_STAGES] its one-cycle-old copy
  logic [SYNC_STAGES:0] vld_pipe_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) vld_pipe_q <= '0;
    else       vld_pipe_q <= {vld_pipe_q[SYNC_STAGES-1:0], async_i};
  end

  assign rise_o = vld_pipe_q[SYNC_STAGES-1] & ~vld_pipe_q[SYNC_STAGES];
endmodule

// File: rtl/timer_digit_entry.sv
// Keypad digit entry for the M:SS countdown chain: shifts BCD digits in,
// loads the counters on start and enables them until terminal count or clear.
module timer_digit_entry
  import timer_pkg::*;
#(
  parameter int     NUM_DIGITS   = 3,
  parameter digit_t SEC_TENS_MAX = SEC_TENS_MAX_DEF,
  parameter int     SYNC_STAGES  = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         key_valid_i,
  input  logic [3:0]   key_code_i,
  input  logic         start_i,
  input  logic         clear_i,
  input  logic         rco_L_i,
  output logic [3:0]   min_ones_o,
  output logic [3:0]   sec_tens_o,
  output logic [3:0]   sec_ones_o,
  output logic         load_o,
  output logic         enablen_o,
  output logic [1:0]   digit_cnt_o,
  output logic         done_o
);
  state_e     state_q, state_d;
  digit_t     min_q, min_d, tens_q, tens_d, ones_q, ones_d;
  logic [1:0] cnt_q, cnt_d;
  logic       load_q, load_d, enn_q, enn_d, done_q, done_d, first_q, first_d;
  logic       key_rise, key_ok, digits_nz;

  key_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_key_edge (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (key_valid_i),
    .rise_o  (key_rise)
  );

  assign key_ok    = key_rise && (key_code_i <= BCD_MAX) && (int'(cnt_q) < NUM_DIGITS);
  assign digits_nz = |{min_q, tens_q, ones_q};

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    cnt_d   = cnt_q;
    enn_d   = enn_q;
    load_d  = 1'b0;
    done_d  = 1'b0;
    first_d = 1'b0;
    if (clear_i) begin
      state_d = ST_IDLE;
      min_d   = '0;
      tens_d  = '0;
      ones_d  = '0;
      cnt_d   = '0;
      enn_d   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_ENTRY: begin
          // start owns the cycle: a coincident key edge is dropped even if start is ignored
          if (start_i) begin
            if (state_q == ST_ENTRY && digits_nz) begin
              state_d = ST_LOAD;
              load_d  = 1'b1;
              tens_d  = clamp_digit(tens_q, SEC_TENS_MAX);
            end
          end else if (key_ok) begin
            min_d   = tens_q;
            tens_d  = ones_q;
            ones_d  = key_code_i;
            cnt_d   = cnt_q + 2'd1;
            state_d = ST_ENTRY;
          end
        end
        ST_LOAD: begin
          state_d = ST_RUN;
          enn_d   = 1'b0;
          first_d = 1'b1;
        end
        ST_RUN: begin
          // rco_L is stale in the cycle right after the parallel load
          if (!first_q && !rco_L_i) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            enn_d   = 1'b1;
            min_d   = '0;
            tens_d  = '0;
            ones_d  = '0;
            cnt_d   = '0;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: begin
          state_d = ST_IDLE;
          enn_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      min_q   <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      enn_q   <= 1'b1;
      done_q  <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      enn_q   <= enn_d;
      done_q  <= done_d;
      first_q <= first_d;
    end
  end

  assign min_ones_o  = min_q;
  assign sec_tens_o  = tens_q;
  assign sec_ones_o  = ones_q;
  assign load_o      = load_q;
  assign enablen_o   = enn_q;
  assign digit_cnt_o = cnt_q;
  assign done_o      = done_q;
endmodule

// File: tb/tb_timer_digit_entry.sv
// Randomized + directed bench for timer_digit_entry against a behavioural model.
module tb_timer_digit_entry;
  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       start, clear, rco_L;
  logic [3:0] min_ones, sec_tens, sec_ones;
  logic       load, enablen, done;
  logic [1:0] digit_cnt;

  always #5 clk = ~clk;

  timer_digit_entry #(.NUM_DIGITS(3), .SEC_TENS_MAX(4'd5), .SYNC_STAGES(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .key_valid_i (key_valid),
    .key_code_i  (key_code),
    .start_i     (start),
    .clear_i     (clear),
    .rco_L_i     (rco_L),
    .min_ones_o  (min_ones),
    .sec_tens_o  (sec_tens),
    .sec_ones_o  (sec_ones),
    .load_o      (load),
    .enablen_o   (enablen),
    .digit_cnt_o (digit_cnt),
    .done_o      (done)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d @%0t", tag, obs, exp, $time);
  endtask

  // Model: entered time kept as a decimal number M*100 + T*10 + O
  localparam int P_IDLE = 0, P_ENTRY = 1, P_LOAD = 2, P_RUN = 3, P_DONE = 4;
  int m_ph, m_val, m_cnt;
  bit m_load, m_enn, m_done, m_first;
  bit m_hist[$];  // key_valid seen at previous edges, newest first

  task automatic m_reset();
    m_ph = P_IDLE; m_val = 0; m_cnt = 0;
    m_load = 0; m_enn = 1; m_done = 0; m_first = 0;
    m_hist = {1'b0, 1'b0, 1'b0};
  endtask

  task automatic m_step(input bit k, input int c, input bit s, input bit cl, input bit r);
    bit rise;
    int t;
    rise = m_hist[1] && !m_hist[2];
    m_hist.push_front(k);
    void'(m_hist.pop_back());
    m_load = 0;
    m_done = 0;
    if (cl) begin
      m_ph = P_IDLE; m_val = 0; m_cnt = 0; m_enn = 1; m_first = 0;
    end else begin
      case (m_ph)
        P_IDLE, P_ENTRY: begin
          if (s) begin
            if (m_ph == P_ENTRY && m_val != 0) begin
              t = (m_val / 10) % 10;
              if (t > 5) m_val -= (t - 5) * 10;
              m_load = 1;
              m_ph = P_LOAD;
            end
          end else if (rise && c <= 9 && m_cnt < 3) begin
            m_val = (m_val * 10 + c) % 1000;
            m_cnt++;
            m_ph = P_ENTRY;
          end
        end
        P_LOAD: begin m_ph = P_RUN; m_enn = 0; m_first = 1; end
        P_RUN: begin
          if (!m_first && !r) begin
            m_ph = P_DONE; m_done = 1; m_enn = 1; m_val = 0; m_cnt = 0;
          end
          m_first = 0;
        end
        default: m_ph = P_IDLE;
      endcase
    end
  endtask

  task automatic cmp_all();
    chk("min_ones", min_ones, m_val / 100);
    chk("sec_tens", sec_tens, (m_val / 10) % 10);
    chk("sec_ones", sec_ones, m_val % 10);
    chk("load", load, m_load);
    chk("enablen", enablen, m_enn);
    chk("digit_cnt", digit_cnt, m_cnt);
    chk("done", done, m_done);
  endtask

  // Drive at negedge, model steps at posedge, compare at next negedge
  task automatic cyc(input bit k, input int c, input bit s, input bit cl, input bit r);
    key_valid = k; key_code = 4'(c); start = s; clear = cl; rco_L = r;
    @(posedge clk);
    m_step(k, c, s, cl, r);
    @(negedge clk);
    cmp_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 1);
  endtask

  task automatic press(input int d);
    repeat (3) cyc(1, d, 0, 0, 1);
    repeat (3) cyc(0, d, 0, 0, 1);
  endtask

  initial begin
    bit k, s, cl, r;
    int c;
    rst = 1; key_valid = 0; key_code = 0; start = 0; clear = 0; rco_L = 1;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    cmp_all();

    // async reset mid-entry
    press(1); press(2);
    chk("entry_cnt2", digit_cnt, 2);
    #2 rst = 1;
    #1;
    chk("arst_digits", {min_ones, sec_tens, sec_ones}, 0);
    chk("arst_cnt", digit_cnt, 0);
    chk("arst_enablen", enablen, 1);
    chk("arst_load", load, 0);
    m_reset();
    @(negedge clk);
    rst = 0;
    cmp_all();

    // entry 1:30, load, run, completion
    press(1); press(3); press(0);
    chk("e_min", min_ones, 1); chk("e_tens", sec_tens, 3); chk("e_ones", sec_ones, 0);
    cyc(0, 0, 1, 0, 1);
    chk("e_load_hi", load, 1); chk("e_enn_load", enablen, 1);
    idle(1);
    chk("e_load_lo", load, 0); chk("e_enn_run", enablen, 0);
    idle(2);
    cyc(0, 0, 0, 0, 0);
    chk("c_done", done, 1); chk("c_enn", enablen, 1);
    chk("c_digits", {min_ones, sec_tens, sec_ones}, 0);
    idle(1);
    chk("c_done_lo", done, 0);

    // clamp and ignored code
    press(9); press(9); press(12);
    chk("cl_cnt", digit_cnt, 2);
    cyc(0, 0, 1, 0, 1);
    chk("cl_load", load, 1); chk("cl_tens", sec_tens, 5); chk("cl_ones", sec_ones, 9);
    cyc(0, 0, 0, 1, 1);
    chk("cl_clear_enn", enablen, 1);

    // saturation, then zero start
    press(4); press(5); press(6); press(7);
    chk("sat_min", min_ones, 4); chk("sat_tens", sec_tens, 5);
    chk("sat_ones", sec_ones, 6); chk("sat_cnt", digit_cnt, 3);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 1, 0, 1);
    chk("zs_load", load, 0);
    idle(1);
    chk("zs_enn", enablen, 1);

    // start and clear together
    press(2);
    cyc(0, 0, 1, 1, 1);
    chk("sc_load", load, 0); chk("sc_cnt", digit_cnt, 0);
    idle(1);
    chk("sc_load2", load, 0);

    // held key accepted once
    repeat (30) cyc(1, 7, 0, 0, 1);
    idle(2);
    chk("hold_cnt", digit_cnt, 1); chk("hold_ones", sec_ones, 7);
    cyc(0, 0, 0, 1, 1);

    // random traffic
    k = 0; c = 0;
    repeat (4000) begin
      if ($urandom_range(3) == 0) k = ~k;
      if (!k && $urandom_range(1) == 1) c = int'($urandom_range(15));
      s  = ($urandom_range(15) == 0);
      cl = ($urandom_range(59) == 0);
      r  = ($urandom_range(5) != 0);
      cyc(k, c, s, cl, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
